// File: rtl/input_irq_conditioner.sv
// Board input conditioner: per-bit 2-FF sync, counter debounce, polarity
// normalisation and sticky edge-pending flags feeding one level interrupt.
module input_irq_conditioner #(
   parameter int unsigned      N_IN            = 13,
   parameter int unsigned      DEBOUNCE_CYCLES = 500000,
   parameter logic [N_IN-1:0]  ACTIVE_LOW_MASK = N_IN'(13'h1C00)
) (
   input  logic            CLOCK_50,
   input  logic            reset,
   input  logic [N_IN-1:0] raw_in,
   input  logic [N_IN-1:0] edge_sel,
   input  logic [N_IN-1:0] irq_en,
   input  logic            pend_clr_valid,
   input  logic [N_IN-1:0] pend_clr_mask,
   output logic [N_IN-1:0] level_out,
   output logic [N_IN-1:0] pending_out,
   output logic            irq
);

   localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [N_IN-1:0]  sync1;
   logic [N_IN-1:0]  sync2;
   logic [N_IN-1:0]  level;
   logic [N_IN-1:0]  toggled;
   logic [N_IN-1:0]  pend;
   logic [N_IN-1:0]  ev;
   logic [N_IN-1:0]  clr;
   logic [CNT_W-1:0] cnt [N_IN];

   // Synchronizer and debounce; toggled marks a level change made on this edge
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         sync1   <= '0;
         sync2   <= '0;
         level   <= '0;
         toggled <= '0;
         for (int i = 0; i < int'(N_IN); i++) cnt[i] <= '0;
      end else begin
         sync1 <= raw_in ^ ACTIVE_LOW_MASK;
         sync2 <= sync1;
         for (int i = 0; i < int'(N_IN); i++) begin
            if (sync2[i] == level[i]) begin
               cnt[i]     <= '0;
               toggled[i] <= 1'b0;
            end else if (cnt[i] == CNT_MAX) begin
               cnt[i]     <= '0;
               level[i]   <= ~level[i];
               toggled[i] <= 1'b1;
            end else begin
               cnt[i]     <= cnt[i] + CNT_W'(1);
               toggled[i] <= 1'b0;
            end
         end
      end
   end

   // Event when the freshly accepted level matches the selected edge direction
   always_comb begin
      ev  = toggled & (level ^ edge_sel);
      clr = pend_clr_valid ? pend_clr_mask : '0;
   end

   // Sticky pending flags; a new event wins over a simultaneous clear
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         pend <= '0;
      end else begin
         pend <= (pend & ~clr) | ev;
      end
   end

   assign level_out   = level;
   assign pending_out = pend;
   assign irq         = |(pend & irq_en);

endmodule

// File: tb/tb_input_irq_conditioner.sv
// Bench for input_irq_conditioner: windowed-history reference model checked
// every cycle, plus literal expectations for the directed scenarios.
module tb_input_irq_conditioner;

   localparam int unsigned N   = 4;
   localparam int unsigned D   = 4;
   localparam logic [3:0]  MSK = 4'b0001;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] raw_in, edge_sel, irq_en, pend_clr_mask;
   logic       pend_clr_valid;
   logic [3:0] level_out, pending_out;
   logic       irq;

   int errors = 0;
   int checks = 0;

   input_irq_conditioner #(
      .N_IN(N), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW_MASK(MSK)
   ) dut (
      .CLOCK_50(clk), .reset(reset), .raw_in(raw_in), .edge_sel(edge_sel),
      .irq_en(irq_en), .pend_clr_valid(pend_clr_valid), .pend_clr_mask(pend_clr_mask),
      .level_out(level_out), .pending_out(pending_out), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: an input change is accepted once the last D post-sync
   // samples (all taken after the previous acceptance or reset) disagree with
   // the accepted level; the edge event lands in pending one edge later.
   logic [3:0] nq[$];
   logic [3:0] samp [0:4095];
   int         since [4];
   int         ecount;
   logic [3:0] mlev, mpend, mtog;
   bit         started = 0;

   always @(posedge clk) begin
      if (reset) begin
         nq = '{4'b0000, 4'b0000};
         for (int i = 0; i < 4; i++) since[i] = 0;
         ecount  = 0;
         mlev    = '0;
         mpend   = '0;
         mtog    = '0;
         started = 1;
      end else if (started) begin
         logic [3:0] s, ev, tog;
         s = nq[nq.size()-2];
         nq.push_back(raw_in ^ MSK);
         samp[ecount] = s;
         for (int i = 0; i < 4; i++) ev[i] = mtog[i] && (mlev[i] == !edge_sel[i]);
         mpend = (mpend & ~(pend_clr_valid ? pend_clr_mask : 4'b0000)) | ev;
         for (int i = 0; i < 4; i++) begin
            tog[i] = 1'b0;
            if (ecount - since[i] + 1 >= int'(D)) begin
               tog[i] = 1'b1;
               for (int k = ecount - int'(D) + 1; k <= ecount; k++)
                  if (samp[k][i] == mlev[i]) tog[i] = 1'b0;
            end
            if (tog[i]) begin
               mlev[i]  = ~mlev[i];
               since[i] = ecount + 1;
            end
         end
         mtog = tog;
         ecount++;
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (started) begin
         check("model_level", 32'(level_out), 32'(mlev));
         check("model_pending", 32'(pending_out), 32'(mpend));
         check("model_irq", 32'(irq), 32'(|(mpend & irq_en)));
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; raw_in = 4'b0001; edge_sel = 4'b0000; irq_en = 4'b0000;
      pend_clr_valid = 1'b0; pend_clr_mask = 4'b0000;

      // 1: idle after reset, active-low key unpressed
      step(5);
      check("reset_level", 32'(level_out), 32'h0);
      check("reset_pending", 32'(pending_out), 32'h0);
      check("reset_irq", 32'(irq), 32'h0);
      reset = 1'b0;
      step(50);
      check("idle_level", 32'(level_out), 32'h0);
      check("idle_pending", 32'(pending_out), 32'h0);
      check("idle_irq", 32'(irq), 32'h0);

      // 2: rising edge on bit 1 with irq enabled
      irq_en = 4'b0010; raw_in = 4'b0011;
      step(5);
      check("t2_level_early", 32'(level_out[1]), 32'h0);
      step(1);
      check("t2_level", 32'(level_out[1]), 32'h1);
      check("t2_pend_early", 32'(pending_out[1]), 32'h0);
      step(1);
      check("t2_pending", 32'(pending_out[1]), 32'h1);
      check("t2_irq", 32'(irq), 32'h1);

      // 3: glitch shorter than the debounce window
      raw_in = 4'b0111; step(3);
      raw_in = 4'b0011; step(10);
      check("t3_level", 32'(level_out[2]), 32'h0);
      check("t3_pending", 32'(pending_out[2]), 32'h0);

      // 4: active-low press, then clear its pending bit
      raw_in = 4'b0010; irq_en = 4'b0001;
      step(7);
      check("t4_level", 32'(level_out[0]), 32'h1);
      check("t4_pending", 32'(pending_out[0]), 32'h1);
      check("t4_irq", 32'(irq), 32'h1);
      pend_clr_valid = 1'b1; pend_clr_mask = 4'b0001;
      step(1);
      pend_clr_valid = 1'b0; pend_clr_mask = 4'b0000;
      check("t4_clr_pending", 32'(pending_out), 32'h2);
      check("t4_clr_irq", 32'(irq), 32'h0);

      // 5: clear of bit 1 coincides with a new falling-edge event on bit 1
      edge_sel = 4'b0010; raw_in = 4'b0000;
      step(6);
      check("t5_level", 32'(level_out[1]), 32'h0);
      pend_clr_valid = 1'b1; pend_clr_mask = 4'b0010;
      step(1);
      pend_clr_valid = 1'b0; pend_clr_mask = 4'b0000;
      check("t5_set_wins", 32'(pending_out[1]), 32'h1);
      pend_clr_valid = 1'b1; pend_clr_mask = 4'b0010;
      step(1);
      pend_clr_valid = 1'b0; pend_clr_mask = 4'b0000;
      check("t5_cleared", 32'(pending_out[1]), 32'h0);
      irq_en = 4'b0000;
      step(3);

      // 6: reset in the middle of a bit-3 debounce
      raw_in = 4'b1000;
      step(4);
      reset = 1'b1;
      step(2);
      check("t6_rst_level", 32'(level_out), 32'h0);
      check("t6_rst_pending", 32'(pending_out), 32'h0);
      check("t6_rst_irq", 32'(irq), 32'h0);
      reset = 1'b0;
      step(5);
      check("t6_level_early", 32'(level_out[3]), 32'h0);
      step(1);
      check("t6_level", 32'(level_out[3]), 32'h1);
      irq_en = 4'b1000;
      step(1);
      check("t6_pending", 32'(pending_out), 32'h9);
      check("t6_irq", 32'(irq), 32'h1);
      step(5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
